// File: rtl/rr_mux_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : rr_mux_sequencer_if
// Description : Request/ack, mux select/capture and valid/ready output bundle
//               for the round-robin mux sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rr_mux_sequencer_if #(
   parameter int WIDTH = 4
) ();
   logic [3:0]       req;
   logic [3:0]       ack;
   logic [1:0]       sel;
   logic [WIDTH-1:0] mux_q;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_ch;
   logic             out_valid;
   logic             out_ready;

   modport master (
      input  req, mux_q, out_ready,
      output ack, sel, out_data, out_ch, out_valid
   );

   modport slave (
      output req, mux_q, out_ready,
      input  ack, sel, out_data, out_ch, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/rr_mux_sequencer.sv
//------------------------------------------------------------------------------
// Module      : rr_mux_sequencer
// Description : Round-robin grant of four requesters onto a 4:1 mux select,
//               dwell-then-capture of the mux output, valid/ready delivery.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_mux_sequencer #(
   parameter int WIDTH = 4,
   parameter int DWELL = 2
) (
   input logic                clk,
   input logic                rst_n,
   rr_mux_sequencer_if.master bus
);

   localparam logic [3:0] c_cnt_last = 4'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [1:0]       r_last;
   logic [1:0]       r_sel;
   logic [3:0]       r_ack;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_ch;
   logic             r_valid;

   logic             w_found;
   logic [1:0]       w_gnt;

   // Search starts one past the last served channel so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = r_last;
      for (int i = 1; i <= 4; i++) begin
         if (!w_found && bus.req[r_last + 2'(i)]) begin
            w_found = 1'b1;
            w_gnt   = r_last + 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_last  <= 2'd3;
         r_sel   <= 2'd0;
         r_ack   <= 4'd0;
         r_data  <= '0;
         r_ch    <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         r_ack <= 4'd0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_sel   <= w_gnt;
                  r_cnt   <= 4'd0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == c_cnt_last) begin
                  r_data  <= bus.mux_q;
                  r_ch    <= r_sel;
                  r_valid <= 1'b1;
                  r_ack   <= 4'b0001 << r_sel;
                  r_last  <= r_sel;
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_HOLD: begin
               if (r_valid && bus.out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sel       = r_sel;
   assign bus.ack       = r_ack;
   assign bus.out_data  = r_data;
   assign bus.out_ch    = r_ch;
   assign bus.out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_rr_mux_sequencer
// Description : Scoreboard bench for rr_mux_sequencer (DWELL=2 and DWELL=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_mux_sequencer;

   typedef struct {
      logic [1:0] ch;
      logic [3:0] data;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] d [4];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   ack_count = 0;
   int   ack_cyc [$];
   exp_t sb [$];

   rr_mux_sequencer_if #(.WIDTH(4)) bus_a ();
   rr_mux_sequencer_if #(.WIDTH(4)) bus_b ();

   // Behavioural stand-in for the combinational 4:1 bus mux.
   assign bus_a.mux_q = d[bus_a.sel];
   assign bus_b.mux_q = d[bus_b.sel];

   rr_mux_sequencer #(.WIDTH(4), .DWELL(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.master)
   );

   rr_mux_sequencer #(.WIDTH(4), .DWELL(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] ch, input logic [3:0] data);
      exp_t e;
      e.ch   = ch;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic wait_acks(input int target, input int budget);
      int n;
      n = 0;
      while (ack_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (ack_count < target) check("ack_timeout", ack_count, target);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Capture monitor: every ack on the DWELL=2 instance pops one expected word.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus_a.ack != 4'd0) begin
         ack_count++;
         ack_cyc.push_back(cyc);
         check("ack_onehot", $countones(bus_a.ack), 1);
         check("ack_with_valid", bus_a.out_valid, 1);
         check("sb_nonempty", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_ch", bus_a.out_ch, e.ch);
            check("out_data", bus_a.out_data, e.data);
            check("ack_bit", bus_a.ack, 4'b0001 << e.ch);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int i0;
      rst_n = 1'b0;
      d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h4; d[3] = 4'h8;
      bus_a.req = 4'd0; bus_a.out_ready = 1'b0;
      bus_b.req = 4'd0; bus_b.out_ready = 1'b1;

      // Reset values and quiet idle
      #2;
      check("rst_sel", bus_a.sel, 0);
      check("rst_ack", bus_a.ack, 0);
      check("rst_data", bus_a.out_data, 0);
      check("rst_ch", bus_a.out_ch, 0);
      check("rst_valid", bus_a.out_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("idle_valid", bus_a.out_valid, 0);
         check("idle_ack", bus_a.ack, 0);
      end

      // Single request, req dropped during settle
      bus_a.req = 4'b0100; bus_a.out_ready = 1'b1;
      push_exp(2'd2, 4'h4);
      @(negedge clk);
      check("t2_sel", bus_a.sel, 2);
      check("t2_valid_e0", bus_a.out_valid, 0);
      bus_a.req = 4'd0;
      @(negedge clk);
      check("t2_valid_e1", bus_a.out_valid, 0);
      @(negedge clk);
      check("t2_valid_e2", bus_a.out_valid, 1);
      check("t2_ack", bus_a.ack, 4'b0100);
      @(negedge clk);
      check("t2_valid_pulse", bus_a.out_valid, 0);
      check("t2_ack_pulse", bus_a.ack, 0);

      // Round robin from a fresh pointer
      do_reset();
      bus_a.req = 4'b1111;
      push_exp(2'd0, 4'h1); push_exp(2'd1, 4'h2); push_exp(2'd2, 4'h4);
      push_exp(2'd3, 4'h8); push_exp(2'd0, 4'h1);
      n0 = ack_count;
      i0 = ack_cyc.size();
      wait_acks(n0 + 5, 60);
      bus_a.req = 4'd0;
      if (ack_cyc.size() >= i0 + 5) begin
         for (int k = 1; k < 5; k++)
            check("t3_gap", ack_cyc[i0 + k] - ack_cyc[i0 + k - 1], 4);
      end
      repeat (2) @(negedge clk);
      check("t3_idle", bus_a.out_valid, 0);

      // Backpressure with mux input changing under a held word
      bus_a.req = 4'b0010; bus_a.out_ready = 1'b0;
      push_exp(2'd1, 4'h2);
      n0 = ack_count;
      @(negedge clk);
      bus_a.req = 4'd0;
      wait_acks(n0 + 1, 20);
      for (int k = 1; k <= 7; k++) begin
         check("t4_valid_hold", bus_a.out_valid, 1);
         check("t4_data_hold", bus_a.out_data, 4'h2);
         check("t4_ch_hold", bus_a.out_ch, 1);
         if (k == 2) d[1] = 4'hF;
         if (k == 7) bus_a.out_ready = 1'b1;
         @(negedge clk);
      end
      check("t4_released", bus_a.out_valid, 0);
      check("t4_single_ack", ack_count - n0, 1);
      d[1] = 4'h2;

      // Pointer priority after channel 1: 3 before 0
      bus_a.req = 4'b1001;
      push_exp(2'd3, 4'h8); push_exp(2'd0, 4'h1);
      n0 = ack_count;
      wait_acks(n0 + 1, 20);
      @(negedge clk);
      check("t5_hs_done", bus_a.out_valid, 0);
      @(negedge clk);
      check("t5_sel_ch0", bus_a.sel, 0);
      bus_a.req = 4'd0;
      wait_acks(n0 + 2, 20);
      @(negedge clk);

      // Asynchronous reset while holding a word
      bus_a.req = 4'b0100; bus_a.out_ready = 1'b0;
      push_exp(2'd2, 4'h4);
      n0 = ack_count;
      @(negedge clk);
      bus_a.req = 4'd0;
      wait_acks(n0 + 1, 20);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_async_valid", bus_a.out_valid, 0);
      check("t6_async_data", bus_a.out_data, 0);
      check("t6_async_sel", bus_a.sel, 0);
      @(negedge clk);
      rst_n = 1'b1; bus_a.out_ready = 1'b1;

      // Reset during settle: in-flight word discarded
      bus_a.req = 4'b0100;
      n0 = ack_count;
      @(negedge clk);
      check("t6_sel_granted", bus_a.sel, 2);
      bus_a.req = 4'd0;
      #6 rst_n = 1'b0;
      #1;
      check("t6_settle_sel", bus_a.sel, 0);
      check("t6_settle_valid", bus_a.out_valid, 0);
      repeat (3) @(negedge clk);
      check("t6_no_ack", ack_count - n0, 0);
      rst_n = 1'b1;
      bus_a.req = 4'b0001;
      push_exp(2'd0, 4'h1);
      @(negedge clk);
      bus_a.req = 4'd0;
      wait_acks(n0 + 1, 20);
      @(negedge clk);

      // DWELL=1 instance: valid one edge after grant
      bus_b.req = 4'b1000;
      @(negedge clk);
      check("b_sel", bus_b.sel, 3);
      check("b_valid_e0", bus_b.out_valid, 0);
      bus_b.req = 4'd0;
      @(negedge clk);
      check("b_valid_e1", bus_b.out_valid, 1);
      check("b_data", bus_b.out_data, 4'h8);
      check("b_ch", bus_b.out_ch, 3);
      check("b_ack", bus_b.ack, 4'b1000);
      @(negedge clk);
      check("b_valid_pulse", bus_b.out_valid, 0);
      check("b_ack_pulse", bus_b.ack, 0);

      @(negedge clk);
      check("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_mux_sequencer.md
# rr_mux_sequencer

Round-robin sequencer that sits around the 4-to-1 bus multiplexer (`mux4a1Bus`). It is upstream of the mux, driving its select input `S`, and downstream of it, capturing its output `Q`. Four sources raise requests. The block grants one at a time, holds the mux select stable for a settle interval, registers the muxed word, and offers it to a consumer over a valid/ready handshake.

## Interface
- `WIDTH`, default 4: data width; matches mux `D0..D3`/`Q`.
- `DWELL`, default 2: settle cycles with `sel` stable before capture. Legal values are 1 to 15.

- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `req`, input, 4: per-channel request, level-sensitive.
- `ack`, output, 4: one-cycle pulse on the granted channel's bit when its word is captured.
- `sel`, output, 2: registered select; drives mux `S`.
- `mux_q`, input, WIDTH: mux output `Q`.
- `out_data`, output, WIDTH: captured word.
- `out_ch`, output, 2: channel that `out_data` came from.
- `out_valid`, output, 1: `out_data`/`out_ch` are valid.
- `out_ready`, input, 1: consumer accepts the word.

## Operation
- Reset values:
  - `sel`=0, `ack`=0, `out_data`=0, `out_ch`=0, `out_valid`=0.
  - State IDLE, settle counter 0.
  - Internal `last_ch`=3, so channel 0 has highest priority first.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If `req`≠0, grant the first set bit searching `last_ch+1`, `last_ch+2`, … modulo 4.
  - On the grant: `sel`←channel, counter←0, go to SETTLE.
  - If `req`=0, remain in IDLE. `sel` holds its previous value.
- SETTLE, evaluated each edge:
  - If counter=DWELL−1: `out_data`←`mux_q`, `out_ch`←`sel`, `out_valid`←1, `ack[sel]`←1, `last_ch`←`sel`, go to HOLD.
  - Otherwise: counter←counter+1.
- HOLD:
  - `ack` returns to 0 after one cycle.
  - `out_data`, `out_ch` and `sel` are frozen while `out_valid`=1 and `out_ready`=0.
  - On an edge with `out_valid`&&`out_ready`: `out_valid`←0, go to IDLE.
- Boundary behaviour:
  - `req` deasserting during SETTLE does not abort; the capture still occurs.
  - `req` changes during HOLD are ignored until IDLE.
  - Only one `ack` bit is ever high at a time.
  - `out_ready` is ignored when `out_valid`=0.
  - A single requesting channel is re-granted on every pass; this is not starvation, since no other channel is waiting.
  - Pointer wrap: after `last_ch`=3 the search starts at 0.
  - Reset asserted in any state: all outputs go to reset values immediately (asynchronously). Any in-flight word is discarded and no `ack` is issued.

## Timing
- Edge E0 is the IDLE edge that sees `req`≠0. `sel` is valid after E0.
- Capture happens at edge E0+DWELL. `out_valid` and `ack` are high in the following cycle.
- Request-to-valid latency is DWELL edges; with the default DWELL=2 that is 2.
- With `out_ready` tied high:
  - The handshake completes at E0+DWELL+1.
  - IDLE at E0+DWELL+2 grants the next channel.
  - Throughput is one word per DWELL+2 cycles.
- `mux_q` is sampled only at the capture edge. The mux is combinational, so with DWELL≥1 `sel` has been stable at least one full cycle at that edge.

## Test plan
Bench instantiates `mux4a1Bus` with `S`=`sel`, `Q`=`mux_q`, and D0..D3 = 4'h1, 4'h2, 4'h4, 4'h8 unless noted. DWELL=2 unless noted.

1. Reset: drive `rst_n`=0 mid-cycle, no clock edge → all outputs 0 at once. Release; `req`=0 for 5 cycles → state stays IDLE, `out_valid`=0.
2. Single request: `req`=4'b0100, `out_ready`=1 → `sel`=2 after E0. At E0+2: `out_data`=4'h4, `out_ch`=2, `ack`=4'b0100 for exactly one cycle, `out_valid` for exactly one cycle.
3. Round robin: `req`=4'b1111 held, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0. Consecutive `out_valid` pulses are 4 cycles apart.
4. Backpressure: `req`=4'b0010, `out_ready`=0 for 6 cycles after valid, then 1 → `out_valid`=1 and `out_data`=4'h2 held for 7 cycles. D1 is changed to 4'hF during the hold; `out_data` must stay 4'h2. A single `ack` pulse is issued.
5. Pointer priority: after a grant of channel 1, set `req`=4'b1001 → channel 3 granted before channel 0. Drop `req` during SETTLE → the capture still occurs.
6. Reset mid-SETTLE plus DWELL=1 variant:
   - Assert `rst_n` low one cycle after the grant → no `ack`, `out_valid`=0, `sel`=0. After release with `req`=4'b0001 → channel 0 granted.
   - With DWELL=1: `out_valid` rises one edge after E0.
